// File: rtl/instr_seq_ctrl_pkg.sv
// instr_seq_pkg: Mini SRC sequencer states, opcodes, bus codes, control bundle.
// Shared by instr_seq_ctrl and its datapath-facing interface.
package instr_seq_pkg;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T1W  = 4'd3;
  localparam logic [3:0] S_T2   = 4'd4;
  localparam logic [3:0] S_DEC  = 4'd5;
  localparam logic [3:0] S_BR3  = 4'd6;
  localparam logic [3:0] S_BR4  = 4'd7;
  localparam logic [3:0] S_BR5  = 4'd8;
  localparam logic [3:0] S_BR6  = 4'd9;
  localparam logic [3:0] S_JR3  = 4'd10;
  localparam logic [3:0] S_JAL3 = 4'd11;
  localparam logic [3:0] S_JAL4 = 4'd12;
  localparam logic [3:0] S_HALT = 4'd13;

  localparam logic [4:0] OP_BR   = 5'b01001;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] BUS_NONE = 5'b00000;
  localparam logic [4:0] BUS_PC   = 5'b10100;
  localparam logic [4:0] BUS_ZLO  = 5'b10011;
  localparam logic [4:0] BUS_MDR  = 5'b10101;
  localparam logic [4:0] BUS_C    = 5'b01100;

  localparam logic [3:0] ALU_ADD = 4'b0011;

  typedef struct packed {
    logic       inc_pc;
    logic       e_pc;
    logic       e_ir;
    logic       e_y;
    logic       e_z;
    logic       e_mar;
    logic       e_mdr;
    logic       e_con_ff;
    logic       ram_read;
    logic       mdr_read;
    logic [3:0] alu_op;
    logic [4:0] bus_sel;
    logic       gra;
    logic       grb;
    logic       e_rout;
    logic       e_rin;
    logic       imm_sel;
    logic       halted;
    logic       busy;
  } ctl_t;

endpackage

// File: rtl/instr_seq_ctrl_if.sv
// instr_seq_ctrl_if: control strobes to the Mini SRC datapath, IR/CON back.
// master = sequencer, slave = datapath.
interface instr_seq_ctrl_if;
  logic [31:0] ir;
  logic        con;
  logic        incPC;
  logic        e_PC;
  logic        e_IR;
  logic        e_Y;
  logic        e_Z;
  logic        e_MAR;
  logic        e_MDR;
  logic        e_CON_FF;
  logic        ram_read;
  logic        MDR_read;
  logic [3:0]  ALU_op;
  logic [4:0]  BusDataSelect;
  logic        Gra;
  logic        Grb;
  logic        e_Rout;
  logic        e_Rin;
  logic        imm_sel;
  logic        halted;
  logic        busy;

  modport master (
    input  ir, con,
    output incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, e_CON_FF,
    output ram_read, MDR_read, ALU_op, BusDataSelect,
    output Gra, Grb, e_Rout, e_Rin, imm_sel, halted, busy
  );

  modport slave (
    output ir, con,
    input  incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, e_CON_FF,
    input  ram_read, MDR_read, ALU_op, BusDataSelect,
    input  Gra, Grb, e_Rout, e_Rin, imm_sel, halted, busy
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: hardwired fetch/decode/execute sequencer for Mini SRC.
// Optional branch counters enabled by INSTR_SEQ_BRCNT_EN.
module instr_seq_ctrl
  import instr_seq_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  instr_seq_ctrl_if.master dp
`ifdef INSTR_SEQ_BRCNT_EN
  ,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken
`endif
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  logic [3:0] state_q, state_d;
  logic [2:0] wait_q, wait_d;
  ctl_t       ctl_q, ctl_d;
  logic [4:0] opc;
  logic [3:0] nxt_instr;

  assign opc       = dp.ir[31:27];
  assign nxt_instr = run ? S_T0 : S_IDLE;

  // next-state and memory-wait counter
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = WAIT_INIT;
      end
      S_T1: begin
        if (wait_q == 3'd0) state_d = S_T1W;
        else wait_d = wait_q - 3'd1;
      end
      S_T1W: state_d = S_T2;
      S_T2:  state_d = S_DEC;
      S_DEC: begin
        case (opc)
          OP_BR:   state_d = S_BR3;
          OP_JR:   state_d = S_JR3;
          OP_JAL:  state_d = S_JAL3;
          OP_HALT: state_d = S_HALT;
          default: state_d = nxt_instr;
        endcase
      end
      S_BR3:  state_d = S_BR4;
      S_BR4:  state_d = S_BR5;
      S_BR5:  state_d = S_BR6;
      S_BR6:  state_d = nxt_instr;
      S_JR3:  state_d = nxt_instr;
      S_JAL3: state_d = S_JAL4;
      S_JAL4: state_d = nxt_instr;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // output decode from next state so strobes line up with the state
  always_comb begin
    ctl_d      = '0;
    ctl_d.busy = (state_d != S_IDLE) && (state_d != S_HALT);
    case (state_d)
      S_T0: begin
        ctl_d.bus_sel = BUS_PC;
        ctl_d.e_mar   = 1'b1;
        ctl_d.inc_pc  = 1'b1;
      end
      S_T1: ctl_d.ram_read = 1'b1;
      S_T1W: begin
        ctl_d.mdr_read = 1'b1;
        ctl_d.e_mdr    = 1'b1;
      end
      S_T2: begin
        ctl_d.bus_sel = BUS_MDR;
        ctl_d.e_ir    = 1'b1;
      end
      S_BR3: begin
        ctl_d.gra      = 1'b1;
        ctl_d.e_rout   = 1'b1;
        ctl_d.e_con_ff = 1'b1;
      end
      S_BR4: begin
        ctl_d.bus_sel = BUS_PC;
        ctl_d.e_y     = 1'b1;
      end
      S_BR5: begin
        ctl_d.bus_sel = BUS_C;
        ctl_d.imm_sel = 1'b1;
        ctl_d.alu_op  = ALU_ADD;
        ctl_d.e_z     = 1'b1;
      end
      S_BR6: begin
        ctl_d.bus_sel = BUS_ZLO;
        ctl_d.e_pc    = dp.con;
      end
      S_JR3, S_JAL4: begin
        ctl_d.gra    = 1'b1;
        ctl_d.e_rout = 1'b1;
        ctl_d.e_pc   = 1'b1;
      end
      S_JAL3: begin
        ctl_d.bus_sel = BUS_PC;
        ctl_d.grb     = 1'b1;
        ctl_d.e_rin   = 1'b1;
      end
      S_HALT: ctl_d.halted = 1'b1;
      default: ;
    endcase
  end

  // state, wait counter and registered controls
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ctl_q   <= ctl_d;
    end
  end

  assign dp.incPC         = ctl_q.inc_pc;
  assign dp.e_PC          = ctl_q.e_pc;
  assign dp.e_IR          = ctl_q.e_ir;
  assign dp.e_Y           = ctl_q.e_y;
  assign dp.e_Z           = ctl_q.e_z;
  assign dp.e_MAR         = ctl_q.e_mar;
  assign dp.e_MDR         = ctl_q.e_mdr;
  assign dp.e_CON_FF      = ctl_q.e_con_ff;
  assign dp.ram_read      = ctl_q.ram_read;
  assign dp.MDR_read      = ctl_q.mdr_read;
  assign dp.ALU_op        = ctl_q.alu_op;
  assign dp.BusDataSelect = ctl_q.bus_sel;
  assign dp.Gra           = ctl_q.gra;
  assign dp.Grb           = ctl_q.grb;
  assign dp.e_Rout        = ctl_q.e_rout;
  assign dp.e_Rin         = ctl_q.e_rin;
  assign dp.imm_sel       = ctl_q.imm_sel;
  assign dp.halted        = ctl_q.halted;
  assign dp.busy          = ctl_q.busy;

`ifdef INSTR_SEQ_BRCNT_EN
  logic [CNT_W-1:0] tot_q, tot_d, tkn_q, tkn_d;

  // count branches retiring in BR6; taken when PC was loaded
  always_comb begin
    tot_d = tot_q;
    tkn_d = tkn_q;
    if (state_q == S_BR6) begin
      tot_d = tot_q + 1'b1;
      if (ctl_q.e_pc) tkn_d = tkn_q + 1'b1;
    end
  end

  // branch counters, cleared only by reset
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      tot_q <= '0;
      tkn_q <= '0;
    end else begin
      tot_q <= tot_d;
      tkn_q <= tkn_d;
    end
  end

  assign br_total = tot_q;
  assign br_taken = tkn_q;
`endif

endmodule
